// File: rtl/nextasic_pkg.sv
// Shared line-protocol constants and receiver state encoding for the
// nextasic serial link (used by both the sender and the receiver).
package nextasic_pkg;

  localparam int DATA_BITS_DEFAULT = 40;

  // Line symbol values
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic TYPE_DATA  = 1'b1;
  localparam logic TYPE_AUDIO = 1'b0;

  // Bit times per data frame: start + type + payload + stop
  localparam int FRAME_BITS = DATA_BITS_DEFAULT + 3;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_TYPE   = 3'd1,
    RX_DATA   = 3'd2,
    RX_STOP   = 3'd3,
    RX_RESYNC = 3'd4
  } rx_state_t;

endpackage

// File: rtl/receiver.sv
// Serial link receiver: decodes audio-request symbols and data frames from
// the one-bit-per-clock line, holding the last accepted payload until acked.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// RX_IDLE   | line idle (1), waiting for a start bit
// RX_TYPE   | sampling type bit: 1 = data frame, 0 = audio request
// RX_DATA   | shifting in DATA_BITS payload bits, MSB first
// RX_STOP   | sampling stop bit; 1 completes the frame, 0 is a framing error
// RX_RESYNC | after a framing error, waiting for the line to return to 1
module receiver
  import nextasic_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sin,
  input  logic                 data_ack,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 audio_sample_request,
  output logic                 data_overrun,
  output logic                 frame_error
);

  // Counter is 6 bits wide, so the payload length is limited to 64 bits.
  localparam logic [5:0] LAST_BIT = 6'(DATA_BITS - 1);

  rx_state_t            r_state;
  logic [5:0]           r_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_audio;
  logic                 r_overrun;
  logic                 r_ferr;

  // A completed frame is accepted if the holding register is empty or is
  // being consumed on this very edge; otherwise it is dropped.
  logic w_accept;
  assign w_accept = !r_valid || data_ack;

  // Line decoder FSM with registered data holding and one-cycle status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= RX_IDLE;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_audio   <= 1'b0;
      r_overrun <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_audio   <= 1'b0;
      r_overrun <= 1'b0;
      r_ferr    <= 1'b0;

      // Consumer handshake; a same-edge frame completion below overrides it.
      if (r_valid && data_ack) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        RX_IDLE: begin
          if (sin == START_BIT) begin
            r_state <= RX_TYPE;
          end
        end

        RX_TYPE: begin
          if (sin == TYPE_DATA) begin
            r_cnt   <= '0;
            r_state <= RX_DATA;
          end else begin
            r_audio <= 1'b1;
            r_state <= RX_IDLE;
          end
        end

        RX_DATA: begin
          r_shift <= {r_shift[DATA_BITS-2:0], sin};
          r_cnt   <= r_cnt + 6'd1;
          if (r_cnt == LAST_BIT) begin
            r_state <= RX_STOP;
          end
        end

        RX_STOP: begin
          if (sin == STOP_BIT) begin
            if (w_accept) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
            end else begin
              r_overrun <= 1'b1;
            end
            r_state <= RX_IDLE;
          end else begin
            r_ferr  <= 1'b1;
            r_state <= RX_RESYNC;
          end
        end

        RX_RESYNC: begin
          // The cycle that samples the 1 only returns to idle; a start bit
          // can be recognised from the following cycle on.
          if (sin == STOP_BIT) begin
            r_state <= RX_IDLE;
          end
        end

        default: begin
          r_state <= RX_IDLE;
        end
      endcase
    end
  end

  assign data                 = r_data;
  assign data_valid           = r_valid;
  assign audio_sample_request = r_audio;
  assign data_overrun         = r_overrun;
  assign frame_error          = r_ferr;

endmodule

// File: tb/tb_receiver.sv
// Self-checking bench for the serial link receiver. Accepted payloads are
// queued when a frame is driven and matched when the DUT presents them.
module tb_receiver;

  localparam int DB = 40;

  logic          clk;
  logic          rst_n;
  logic          sin;
  logic          data_ack;
  logic [DB-1:0] data;
  logic          data_valid;
  logic          audio_sample_request;
  logic          data_overrun;
  logic          frame_error;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DB-1:0] sb_q[$];

  int cnt_audio = 0;
  int cnt_ovr   = 0;
  int cnt_ferr  = 0;

  logic [DB-1:0] prev_data  = '0;
  logic          prev_valid = 1'b0;

  receiver #(.DATA_BITS(DB)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .sin                  (sin),
    .data_ack             (data_ack),
    .data                 (data),
    .data_valid           (data_valid),
    .audio_sample_request (audio_sample_request),
    .data_overrun         (data_overrun),
    .frame_error          (frame_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: a newly presented payload (valid rising or data
  // changing) must match the oldest expected frame.
  always @(negedge clk) begin
    if (rst_n) begin
      cnt_audio += int'(audio_sample_request);
      cnt_ovr   += int'(data_overrun);
      cnt_ferr  += int'(frame_error);
      if ((data !== prev_data) || (data_valid && !prev_valid)) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected", 64'(data), 64'(prev_data));
        end else begin
          chk("sb_data", 64'(data), 64'(sb_q.pop_front()));
          chk("sb_valid", 64'(data_valid), 64'd1);
        end
      end
    end
    prev_data  = data;
    prev_valid = data_valid;
  end

  task automatic drive(input logic b);
    @(negedge clk);
    sin      = b;
    data_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1);
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    sin      = 1'b1;
    data_ack = 1'b1;
  endtask

  // Drives start, type=1, payload and stop; optionally acks on the stop bit.
  task automatic send_frame(input logic [DB-1:0] p, input logic stop_b,
                            input bit ack_on_stop, input bit expect_accept);
    if (expect_accept) sb_q.push_back(p);
    drive(1'b0);
    drive(1'b1);
    for (int i = DB - 1; i >= 0; i--) drive(p[i]);
    @(negedge clk);
    sin      = stop_b;
    data_ack = ack_on_stop ? 1'b1 : 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_data"},  64'(data), 64'd0);
    chk({tag, "_valid"}, 64'(data_valid), 64'd0);
    chk({tag, "_audio"}, 64'(audio_sample_request), 64'd0);
    chk({tag, "_ovr"},   64'(data_overrun), 64'd0);
    chk({tag, "_ferr"},  64'(frame_error), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, o0, f0;
    logic [DB-1:0] f91, f93, f97;
    f91 = 40'hD999999991;
    f93 = 40'hD999999993;
    f97 = 40'hD999999997;

    rst_n    = 1'b0;
    sin      = 1'b1;
    data_ack = 1'b0;
    #1;
    check_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle line
    idle(200);
    check_zero("idle200");
    chk("idle_pulses", 64'(cnt_audio + cnt_ovr + cnt_ferr), 64'd0);

    // Ack with nothing held is ignored
    ack_pulse();
    drive(1'b1);
    chk("ack_empty_valid", 64'(data_valid), 64'd0);
    chk("ack_empty_data", 64'(data), 64'd0);

    // Single frame, hold, ack
    send_frame(f91, 1'b1, 1'b0, 1'b1);
    drive(1'b1);
    chk("f1_valid_at_stop", 64'(data_valid), 64'd1);
    chk("f1_data", 64'(data), 64'(f91));
    for (int i = 0; i < 10; i++) begin
      drive(1'b1);
      chk("f1_hold_valid", 64'(data_valid), 64'd1);
    end
    ack_pulse();
    drive(1'b1);
    chk("f1_cleared", 64'(data_valid), 64'd0);
    chk("f1_data_kept", 64'(data), 64'(f91));

    // Back-to-back, no ack: second frame dropped with overrun
    o0 = cnt_ovr;
    send_frame(f93, 1'b1, 1'b0, 1'b1);
    send_frame(f97, 1'b1, 1'b0, 1'b0);
    drive(1'b1);
    chk("ovr_pulse", 64'(data_overrun), 64'd1);
    chk("ovr_data", 64'(data), 64'(f93));
    chk("ovr_valid", 64'(data_valid), 64'd1);
    drive(1'b1);
    chk("ovr_pulse_end", 64'(data_overrun), 64'd0);
    chk("ovr_count", 64'(cnt_ovr - o0), 64'd1);
    ack_pulse();
    idle(3);
    chk("ovr_cleared", 64'(data_valid), 64'd0);

    // Back-to-back with ack on the second stop edge
    o0 = cnt_ovr;
    send_frame(f93, 1'b1, 1'b0, 1'b1);
    send_frame(f97, 1'b1, 1'b1, 1'b1);
    drive(1'b1);
    chk("ackstop_data", 64'(data), 64'(f97));
    chk("ackstop_valid", 64'(data_valid), 64'd1);
    idle(3);
    chk("ackstop_no_ovr", 64'(cnt_ovr - o0), 64'd0);
    ack_pulse();
    idle(3);

    // Audio request symbols, one every 114 cycles
    a0 = cnt_audio;
    for (int s = 0; s < 3; s++) begin
      drive(1'b0);
      drive(1'b0);
      chk("audio_after_start", 64'(audio_sample_request), 64'd0);
      drive(1'b1);
      chk("audio_after_type", 64'(audio_sample_request), 64'd1);
      drive(1'b1);
      chk("audio_one_cycle", 64'(audio_sample_request), 64'd0);
      idle(110);
    end
    chk("audio_count", 64'(cnt_audio - a0), 64'd3);

    // Framing error, resync, then a good frame
    f0 = cnt_ferr;
    send_frame(f93, 1'b0, 1'b0, 1'b0);
    drive(1'b0);
    chk("ferr_pulse", 64'(frame_error), 64'd1);
    chk("ferr_no_valid", 64'(data_valid), 64'd0);
    for (int i = 0; i < 9; i++) drive(1'b0);
    drive(1'b1);
    send_frame(f91, 1'b1, 1'b0, 1'b1);
    drive(1'b1);
    chk("resync_data", 64'(data), 64'(f91));
    chk("resync_valid", 64'(data_valid), 64'd1);
    chk("ferr_count", 64'(cnt_ferr - f0), 64'd1);
    ack_pulse();
    idle(3);

    // Reset in the middle of a payload
    o0 = cnt_ovr;
    f0 = cnt_ferr;
    drive(1'b0);
    drive(1'b1);
    for (int i = DB - 1; i >= DB - 20; i--) drive(f93[i]);
    @(negedge clk);
    rst_n = 1'b0;
    sin   = 1'b1;
    #1;
    check_zero("midrst_now");
    repeat (2) @(negedge clk);
    check_zero("midrst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    chk("midrst_no_valid", 64'(data_valid), 64'd0);
    send_frame(f93, 1'b1, 1'b0, 1'b1);
    drive(1'b1);
    chk("postrst_data", 64'(data), 64'(f93));
    chk("postrst_valid", 64'(data_valid), 64'd1);
    idle(3);
    chk("postrst_no_errs", 64'((cnt_ovr - o0) + (cnt_ferr - f0)), 64'd0);

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/receiver.md
RECEIVER -- requirements
Module: receiver

Interface
REQ-001 Parameter DATA_BITS, default 40, payload bits per data frame.
REQ-002 clk  input  1  bit clock; one line bit per rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 sin  input  1  serial line, synchronous to clk, idles at 1.
REQ-005 data_ack  input  1  consumer accepts held frame when high with data_valid.
REQ-006 data  output  DATA_BITS  last accepted payload, MSB = first bit received.
REQ-007 data_valid  output  1  level; high while data holds an unconsumed frame.
REQ-008 audio_sample_request  output  1  one-cycle pulse per received request symbol.
REQ-009 data_overrun  output  1  one-cycle pulse when a valid frame is dropped.
REQ-010 frame_error  output  1  one-cycle pulse when a stop bit samples 0.

Function
REQ-011 Line format SHALL be: start bit 0, type bit, then for type 1 the DATA_BITS payload MSB-first and a stop bit 1; for type 0 there are no further bits.
REQ-012 States SHALL be IDLE, TYPE, DATA, STOP and RESYNC.
REQ-013 IDLE: sin=0 SHALL go to TYPE; sin=1 stays in IDLE.
REQ-014 TYPE: sin=1 SHALL clear the bit counter and go to DATA.
REQ-015 TYPE: sin=0 SHALL raise audio_sample_request on that same edge for exactly one cycle and go to IDLE.
REQ-016 DATA: each edge SHALL shift sin into the LSB of a DATA_BITS shift register and increment a 6-bit counter; after counter value DATA_BITS-1 the next state is STOP.
REQ-017 STOP with sin=1 SHALL complete the frame and go to IDLE.
REQ-018 STOP with sin=0 SHALL pulse frame_error for one cycle, discard the frame and go to RESYNC.
REQ-019 RESYNC SHALL stay until sin=1, then go to IDLE; no start is recognized in the cycle that samples that 1.
REQ-020 On frame completion with data_valid=0, data SHALL load the shift register and data_valid SHALL rise on the same edge.
REQ-021 data_valid=1 with data_ack=1 SHALL clear data_valid on the next edge.
REQ-022 Frame completion with data_valid=1 and data_ack=1 on the same edge SHALL load the new frame, keep data_valid=1 and raise no overrun.
REQ-023 Frame completion with data_valid=1 and data_ack=0 SHALL pulse data_overrun for one cycle and leave data and data_valid unchanged.
REQ-024 data_ack while data_valid=0 SHALL be ignored.
REQ-025 data SHALL change only on an accepted frame.
REQ-026 A data frame occupies 43 bit times, and back-to-back frames (start bit in the cycle after stop) SHALL be received without loss.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, counter 0, shift register 0, data 0 and all single-bit outputs 0.
REQ-028 Reset mid-frame SHALL abort the frame with no data_valid, frame_error or overrun, and the first frame after release SHALL be received normally.

Structure
REQ-029 Package nextasic_pkg SHALL hold DATA_BITS default, start, stop and type bit constants, and the receiver state enum, shared with sender.
REQ-030 The block SHALL be a single module with no sub-module.

Verification
REQ-031 sin=1 for 200 cycles -> all outputs remain 0.
REQ-032 Frame 40'hD999999991 with stop 1 -> data_valid rises at the stop edge with data=40'hD999999991, stays high for 10 idle cycles, and clears one edge after a one-cycle data_ack.
REQ-033 Frames 40'hD999999993 then 40'hD999999997 back-to-back, no ack -> data=40'hD999999993, one data_overrun pulse at the second stop edge; repeating with ack asserted at that edge -> data=40'hD999999997, no overrun.
REQ-034 Start bit 0 at edge n, type bit 0 at edge n+1 -> audio_sample_request high only after edge n+1; repeating every 114 cycles -> one pulse per symbol.
REQ-035 Stop bit 0 -> one frame_error pulse and no data_valid; then sin=0 for 10 cycles, 1 for 1 cycle, and frame 40'hD999999991 -> received correctly.
REQ-036 rst_n low for 3 cycles at payload bit 20 -> outputs 0 during reset; the next full frame 40'hD999999993 is received correctly.
